// File: rtl/timer_pkg.sv
// Shared register map, bit positions and bus width for the Avalon interval timer.
package timer_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

endpackage

// File: rtl/timer_down_counter.sv
// Down counter with reload-on-zero, run/continuous control and sticky timeout flag.
module timer_down_counter #(
  parameter int                 COUNT_W   = 32,
  parameter logic [COUNT_W-1:0] RESET_VAL = '0,
  parameter bit                 RESET_RUN = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [COUNT_W-1:0] period_i,
  input  logic               ctrl_wr_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               cont_i,
  input  logic               to_clr_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               run_o,
  output logic               cont_o,
  output logic               to_o
);

  logic [COUNT_W-1:0] count_q, count_d;
  logic               run_q, run_d;
  logic               cont_q, cont_d;
  logic               to_q, to_d;

  // Clear is applied first so a timeout in the same cycle leaves TO set.
  always_comb begin
    count_d = count_q;
    run_d   = run_q;
    cont_d  = cont_q;
    to_d    = to_q;
    if (to_clr_i) to_d = 1'b0;
    if (load_i) begin
      count_d = period_i;
      run_d   = 1'b0;
    end else if (run_q && (count_q == '0)) begin
      count_d = period_i;
      to_d    = 1'b1;
      run_d   = cont_q;
    end else if (run_q) begin
      count_d = count_q - 1'b1;
    end
    if (ctrl_wr_i) begin
      cont_d = cont_i;
      if (stop_i)       run_d = 1'b0;
      else if (start_i) run_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RESET_VAL;
      run_q   <= RESET_RUN;
      cont_q  <= RESET_RUN;
      to_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      run_q   <= run_d;
      cont_q  <= cont_d;
      to_q    <= to_d;
    end
  end

  assign count_o = count_q;
  assign run_o   = run_q;
  assign cont_o  = cont_q;
  assign to_o    = to_q;

endmodule

// File: rtl/avalon_interval_timer_param.sv
// Avalon-MM 16-bit slave interval timer: register decode, period/snapshot storage,
// registered read mux and level interrupt.
module avalon_interval_timer_param
  import timer_pkg::*;
#(
  parameter int          COUNT_W      = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h02FAF07F,
  parameter bit          RESET_RUN    = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [2:0]        address,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq
);

  localparam int                 HI_W       = COUNT_W - DATA_W;
  localparam logic [COUNT_W-1:0] RST_PERIOD = RESET_PERIOD[COUNT_W-1:0];

  logic               wr_en;
  logic               wr_status, wr_control, wr_periodl, wr_periodh, wr_snapl;
  logic [COUNT_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0] snap_q, snap_d;
  logic               ito_q, ito_d;
  logic [DATA_W-1:0]  rd_q, rd_d;
  logic [COUNT_W-1:0] count;
  logic               run, cont, to;

  assign wr_en      = chipselect & ~write_n;
  assign wr_status  = wr_en && (address == ADDR_STATUS);
  assign wr_control = wr_en && (address == ADDR_CONTROL);
  assign wr_periodl = wr_en && (address == ADDR_PERIODL);
  assign wr_periodh = wr_en && (address == ADDR_PERIODH);
  assign wr_snapl   = wr_en && (address == ADDR_SNAPL);

  // The counter reloads from period_d, so a period write lands in the counter on the same edge.
  always_comb begin
    period_d = period_q;
    if (wr_periodl) period_d[DATA_W-1:0]       = writedata;
    if (wr_periodh) period_d[COUNT_W-1:DATA_W] = writedata[HI_W-1:0];
  end

  assign snap_d = wr_snapl   ? count : snap_q;
  assign ito_d  = wr_control ? writedata[CTRL_ITO] : ito_q;

  timer_down_counter #(
    .COUNT_W   (COUNT_W),
    .RESET_VAL (RST_PERIOD),
    .RESET_RUN (RESET_RUN)
  ) u_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (wr_periodl | wr_periodh),
    .period_i  (period_d),
    .ctrl_wr_i (wr_control),
    .start_i   (writedata[CTRL_START]),
    .stop_i    (writedata[CTRL_STOP]),
    .cont_i    (writedata[CTRL_CONT]),
    .to_clr_i  (wr_status),
    .count_o   (count),
    .run_o     (run),
    .cont_o    (cont),
    .to_o      (to)
  );

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_STATUS: begin
        rd_d[STAT_RUN] = run;
        rd_d[STAT_TO]  = to;
      end
      ADDR_CONTROL: begin
        rd_d[CTRL_CONT] = cont;
        rd_d[CTRL_ITO]  = ito_q;
      end
      ADDR_PERIODL: rd_d = period_q[DATA_W-1:0];
      ADDR_PERIODH: rd_d = DATA_W'(period_q[COUNT_W-1:DATA_W]);
      ADDR_SNAPL:   rd_d = snap_q[DATA_W-1:0];
      ADDR_SNAPH:   rd_d = DATA_W'(snap_q[COUNT_W-1:DATA_W]);
      default:      rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= RST_PERIOD;
      snap_q   <= '0;
      ito_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      period_q <= period_d;
      snap_q   <= snap_d;
      ito_q    <= ito_d;
      rd_q     <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = to & ito_q;

endmodule

// File: tb/tb_avalon_interval_timer_param.sv
// Self-checking bench for avalon_interval_timer_param with default parameters.
module tb_avalon_interval_timer_param;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'h0000;
  logic [15:0] readdata;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  avalon_interval_timer_param dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0000;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(posedge clk); #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0]  addrs [8];
    logic [15:0] exps  [8];
    logic [15:0] got;
    logic [31:0] e;
    addrs = '{ADDR_STATUS, ADDR_CONTROL, ADDR_PERIODL, ADDR_PERIODH,
              ADDR_SNAPL, ADDR_SNAPH, 3'd6, 3'd7};
    exps  = '{16'h0000, 16'h0000, 16'hF07F, 16'h02FA, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    reset_n = 1'b0;
    idle(3);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front();
    checks++;
    if ({31'b0, irq} !== e) begin
      failures++; $display("FAIL reset_irq got=%0h exp=%0h", irq, e);
    end
    exp_q.push_back(32'h0);
    e = exp_q.pop_front();
    checks++;
    if ({16'b0, readdata} !== e) begin
      failures++; $display("FAIL reset_readdata got=%h exp=%h", readdata, e[15:0]);
    end
    reset_n = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({16'b0, exps[i]});
      bus_read(addrs[i], got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e[15:0]) begin
        failures++; $display("FAIL reset_read addr=%0d got=%h exp=%h", addrs[i], got, e[15:0]);
      end
    end
  endtask

  task automatic test_continuous();
    logic [31:0] e;
    bus_write(ADDR_PERIODL, 16'd9);
    bus_write(ADDR_PERIODH, 16'd0);
    bus_write(ADDR_CONTROL, 16'h0007);
    for (int k = 1; k <= 22; k++) begin
      exp_q.push_back(((k == 10) || (k >= 20)) ? 32'd1 : 32'd0);
      if (k == 11) bus_write(ADDR_STATUS, 16'h0000);
      else         idle(1);
      e = exp_q.pop_front();
      checks++;
      if ({31'b0, irq} !== e) begin
        failures++; $display("FAIL cont_irq cycle=%0d got=%0d exp=%0d", k, irq, e);
      end
    end
    bus_write(ADDR_CONTROL, 16'h0008);
    bus_write(ADDR_STATUS, 16'h0000);
  endtask

  task automatic test_one_shot();
    logic [15:0] got;
    logic [31:0] e;
    bus_write(ADDR_PERIODL, 16'd4);
    bus_write(ADDR_PERIODH, 16'd0);
    bus_write(ADDR_CONTROL, 16'h0005);
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back((k >= 5) ? 32'd1 : 32'd0);
      idle(1);
      e = exp_q.pop_front();
      checks++;
      if ({31'b0, irq} !== e) begin
        failures++; $display("FAIL oneshot_irq cycle=%0d got=%0d exp=%0d", k, irq, e);
      end
    end
    exp_q.push_back(32'h0001);
    bus_read(ADDR_STATUS, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e[15:0]) begin
      failures++; $display("FAIL oneshot_status got=%h exp=%h", got, e[15:0]);
    end
    bus_write(ADDR_SNAPL, 16'h0000);
    exp_q.push_back(32'h0004);
    exp_q.push_back(32'h0000);
    bus_read(ADDR_SNAPL, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e[15:0]) begin
      failures++; $display("FAIL oneshot_snapl got=%h exp=%h", got, e[15:0]);
    end
    bus_read(ADDR_SNAPH, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e[15:0]) begin
      failures++; $display("FAIL oneshot_snaph got=%h exp=%h", got, e[15:0]);
    end
    bus_write(ADDR_STATUS, 16'h0000);
    bus_write(ADDR_CONTROL, 16'h0000);
  endtask

  task automatic test_period_write_stop();
    logic [2:0]  addrs [5];
    logic [15:0] got;
    logic [31:0] e;
    bus_write(ADDR_PERIODL, 16'h1234);
    bus_write(ADDR_PERIODH, 16'h0000);
    bus_write(ADDR_CONTROL, 16'h0004);
    idle(3);
    bus_write(ADDR_PERIODH, 16'h0001);
    addrs = '{ADDR_STATUS, ADDR_PERIODL, ADDR_PERIODH, ADDR_SNAPL, ADDR_SNAPH};
    exp_q.push_back(32'h0000);
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h0001);
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h0001);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) bus_write(ADDR_SNAPL, 16'hFFFF);
      bus_read(addrs[i], got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e[15:0]) begin
        failures++; $display("FAIL pwrite_read idx=%0d got=%h exp=%h", i, got, e[15:0]);
      end
    end
    bus_write(ADDR_CONTROL, 16'h0004);
    exp_q.push_back(32'h0002);
    bus_read(ADDR_STATUS, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e[15:0]) begin
      failures++; $display("FAIL start_status got=%h exp=%h", got, e[15:0]);
    end
    bus_write(ADDR_SNAPL, 16'h0000);
    exp_q.push_back(32'h1233);
    exp_q.push_back(32'h0001);
    bus_read(ADDR_SNAPL, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e[15:0]) begin
      failures++; $display("FAIL resume_snapl got=%h exp=%h", got, e[15:0]);
    end
    bus_read(ADDR_SNAPH, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e[15:0]) begin
      failures++; $display("FAIL resume_snaph got=%h exp=%h", got, e[15:0]);
    end
    bus_write(ADDR_CONTROL, 16'h000C);
    exp_q.push_back(32'h0000);
    bus_read(ADDR_STATUS, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e[15:0]) begin
      failures++; $display("FAIL stopstart_status got=%h exp=%h", got, e[15:0]);
    end
  endtask

  task automatic test_snapshot();
    logic [15:0] got;
    logic [31:0] e;
    bus_write(ADDR_PERIODL, 16'd99);
    bus_write(ADDR_PERIODH, 16'd0);
    bus_write(ADDR_CONTROL, 16'h0006);
    idle(20);
    bus_write(ADDR_SNAPL, 16'h0000);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(32'd79);
      exp_q.push_back(32'd0);
      bus_read(ADDR_SNAPL, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e[15:0]) begin
        failures++; $display("FAIL snap_low pass=%0d got=%h exp=%h", r, got, e[15:0]);
      end
      bus_read(ADDR_SNAPH, got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e[15:0]) begin
        failures++; $display("FAIL snap_high pass=%0d got=%h exp=%h", r, got, e[15:0]);
      end
      idle(30);
    end
    bus_write(ADDR_CONTROL, 16'h0008);
    bus_write(ADDR_STATUS, 16'h0000);
  endtask

  task automatic test_coincident_and_async_reset();
    logic [15:0] got;
    logic [31:0] e;
    bus_write(ADDR_PERIODL, 16'd3);
    bus_write(ADDR_PERIODH, 16'd0);
    bus_write(ADDR_CONTROL, 16'h0007);
    idle(3);
    bus_write(ADDR_STATUS, 16'h0000);
    exp_q.push_back(32'h0003);
    exp_q.push_back(32'h1);
    bus_read(ADDR_STATUS, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e[15:0]) begin
      failures++; $display("FAIL coincident_status got=%h exp=%h", got, e[15:0]);
    end
    e = exp_q.pop_front();
    checks++;
    if ({31'b0, irq} !== e) begin
      failures++; $display("FAIL coincident_irq got=%0d exp=%0d", irq, e);
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h02FAF07F);
    reset_n = 1'b0;
    #2;
    e = exp_q.pop_front();
    checks++;
    if ({31'b0, irq} !== e) begin
      failures++; $display("FAIL async_irq got=%0d exp=%0d", irq, e);
    end
    e = exp_q.pop_front();
    checks++;
    if ({16'b0, readdata} !== e) begin
      failures++; $display("FAIL async_readdata got=%h exp=%h", readdata, e[15:0]);
    end
    e = exp_q.pop_front();
    checks++;
    if (dut.u_counter.count_q !== e) begin
      failures++; $display("FAIL async_counter got=%h exp=%h", dut.u_counter.count_q, e);
    end
    #2;
    reset_n = 1'b1;
    idle(1);
    exp_q.push_back(32'h0000);
    exp_q.push_back(32'hF07F);
    bus_read(ADDR_STATUS, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e[15:0]) begin
      failures++; $display("FAIL post_reset_status got=%h exp=%h", got, e[15:0]);
    end
    bus_read(ADDR_PERIODL, got);
    e = exp_q.pop_front();
    checks++;
    if (got !== e[15:0]) begin
      failures++; $display("FAIL post_reset_periodl got=%h exp=%h", got, e[15:0]);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_continuous();
    test_one_shot();
    test_period_write_stop();
    test_snapshot();
    test_coincident_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
